// File: rtl/ha_array_collector.sv
// ha_array_collector: captures four ha_array b/t row pairs and accumulates them serially into a 16-bit product plus ovf.
// Latency 4 cycles from accept to out_valid; holds result while out_ready is low, no accept until the result is taken.
// HA_COLLECT_STATUS_EN adds the txn_count completed-handshake counter port.
module ha_array_collector (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  ha_array_0_b,
  input  logic [6:0]  ha_array_1_b,
  input  logic [6:0]  ha_array_2_b,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [8:0]  ha_array_1_t,
  input  logic [8:0]  ha_array_2_t,
  input  logic [8:0]  ha_array_3_t,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        ovf
`ifdef HA_COLLECT_STATUS_EN
  ,
  output logic [7:0]  txn_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [6:0] b;
    logic [8:0] t;
  } row_t;

  state_t      state_q;
  state_t      state_d;
  row_t [3:0]  rows_q;
  logic [16:0] acc_q;
  logic [1:0]  idx_q;
  logic        accept;
  logic        add_en;
  row_t        cur_row;
  logic [9:0]  row_val;
  logic [16:0] term;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_en    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ACC;
      end
      ACC: begin
        add_en = 1'b1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // b[k] sits two columns above t[k]; each row is offset by two columns from the previous one.
  always_comb begin
    cur_row = rows_q[idx_q];
    row_val = 10'(cur_row.t) + {1'b0, cur_row.b, 2'b00};
    term    = 17'(row_val) << {idx_q, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      rows_q[0] <= '{b: ha_array_0_b, t: ha_array_0_t};
      rows_q[1] <= '{b: ha_array_1_b, t: ha_array_1_t};
      rows_q[2] <= '{b: ha_array_2_b, t: ha_array_2_t};
      rows_q[3] <= '{b: ha_array_3_b, t: ha_array_3_t};
      acc_q     <= '0;
      idx_q     <= '0;
    end else if (add_en) begin
      acc_q <= acc_q + term;
      idx_q <= idx_q + 2'd1;
    end
  end

  assign product = acc_q[15:0];
  assign ovf     = acc_q[16];

`ifdef HA_COLLECT_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      txn_count <= '0;
    else if (out_valid && out_ready) txn_count <= txn_count + 8'd1;
  end
`endif

endmodule

// File: doc/ha_array_collector.md
# ha_array_collector

Back-end consumer for the 8x8 unsigned approximate multiplier's half-adder-array front end. It accepts the four `ha_array_<r>_b` / `ha_array_<r>_t` row pairs in one handshake. It then accumulates the rows serially, one per cycle, into a 16-bit product. The product is returned through a valid/ready output port. It sits between the combinational ha_array stage and any downstream register or arithmetic consumer, breaking the long reduction path.

## Interface
Parameters:
- none; widths are fixed by the ha_array format (7-bit `b`, 9-bit `t`, 4 rows, 16-bit product).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ha_array_0_b` .. `ha_array_3_b`  in  7 each  bottom (carry) vector of row r.
- `ha_array_0_t` .. `ha_array_3_t`  in  9 each  top (sum) vector of row r.
- `in_valid`  in  1  row set on the `ha_array_*` inputs is valid.
- `in_ready`  out  1  block can accept a row set.
- `out_valid`  out  1  `product` / `ovf` are valid.
- `out_ready`  in  1  downstream accepts the result.
- `product`  out  16  accumulated result, mod 2^16.
- `ovf`  out  1  true sum was ≥ 65536 (only reachable with non-multiplier input patterns).
- `txn_count`  out  8  completed output handshakes; present only with `HA_COLLECT_STATUS_EN`.

## Operation
- Row value: V_r = t_r + (b_r << 2).
  - `t[k]` has weight 2^k.
  - `b[k]` has weight 2^(k+2).
- Row weight: row r contributes V_r << 2r. Result = Σ_r (V_r << 2r).
- Accumulator: 17 bits (max legal-format sum 86615 < 2^17).
  - `product` = acc[15:0].
  - `ovf` = acc[16].
- Input capture: on `in_valid && in_ready`, all 64 input bits are latched into an internal row register. The inputs may change freely afterwards.
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0. On accept, clear acc, set row index to 0, go to ACC.
  - ACC: each cycle, acc += V_idx << 2·idx, then idx++. When idx==3 has been added, go to DONE. `in_ready`=0.
  - DONE: `out_valid`=1 and `product` / `ovf` are held stable. On `out_ready`, go to IDLE. `in_ready`=0.
- No accept is possible in DONE. A new operation starts only after the DONE→IDLE transition.
- Row index is 2 bits and is cleared on every accept. It never wraps mid-operation.

## Timing
- Reset values (async assert, sync-free deassert): state=IDLE, acc=0, idx=0, `in_ready`=1, `out_valid`=0, `product`=0, `ovf`=0, `txn_count`=0.
- Latency: accept on edge E0. Rows 0..3 are added on E1..E4. `out_valid` is high from E4 onward, i.e. 4 cycles after accept.
- Throughput: one result per 6 cycles when `out_ready` is held high. The cycles are accept, 4×ACC, DONE, with IDLE for the next accept.
- `out_ready` is sampled only in DONE. `out_ready` high with `out_valid` low has no effect.
- `in_valid` deassertion is allowed without handshake. `in_valid` is ignored while `in_ready`=0.
- `rst_n` asserted mid-ACC or mid-DONE: the block immediately returns to reset values. The pending result is discarded with no `out_valid` pulse.

## Configuration
- `HA_COLLECT_STATUS_EN` defined:
  - `txn_count` port and register exist.
  - The counter increments on each `out_valid && out_ready` and wraps 255→0.
- Not defined:
  - The port and register are absent.
  - All other behaviour is identical.

## Test plan
- All row inputs 0, `in_valid` pulse, `out_ready`=1 → `out_valid` exactly 4 cycles after accept, `product`=0x0000, `ovf`=0.
- Only `ha_array_0_t`=9'h001 → `product`=0x0001.
- Only `ha_array_1_t`=9'h1FF → `product`=0x07FC.
- Only `ha_array_3_b`=7'h40 → `product`=0x4000.
- All inputs all-ones → `product`=0x5257, `ovf`=1.
- Backpressure and reset: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - Required: `product` stable, `in_ready`=0, and a new `in_valid` is ignored.
  - Then pulse `rst_n` low mid-ACC on the next transaction. Required: outputs return to reset values, and `txn_count` (if enabled) is reset to 0.
